// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and helpers for the UART command parser.
// The parser FSM and the response serializer both import this package.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_G  = 8'h47;
  localparam logic [7:0] ASCII_B  = 8'h42;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_Q  = 8'h3F;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;

  localparam logic [2:0] RESP_LEN_ACK   = 3'd4;
  localparam logic [2:0] RESP_LEN_QUERY = 3'd5;

  typedef enum logic [1:0] {COLLECT, EXEC, TX_LOAD, TX_WAIT} state_e;

  // Pins are active-low, so a low pin reports as lit ('1').
  function automatic logic [7:0] led_digit(input logic pin);
    return pin ? ASCII_0 : ASCII_1;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-level link between the UART RX/TX pair, the LED pins and the command parser.
// The parser takes the slave view; the surrounding top level or bench takes the master view.
interface uart_cmd_parser_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic       i_TX_Active;
  logic       i_TX_Done;
  logic       o_LED_R;
  logic       o_LED_G;
  logic       o_LED_B;
  logic       o_Cmd_Err;
  logic       o_Overrun;

  modport slave (
    input  i_RX_DV, i_RX_Byte, i_TX_Active, i_TX_Done,
    output o_TX_DV, o_TX_Byte, o_LED_R, o_LED_G, o_LED_B, o_Cmd_Err, o_Overrun
  );

  modport master (
    output i_RX_DV, i_RX_Byte, i_TX_Active, i_TX_Done,
    input  o_TX_DV, o_TX_Byte, o_LED_R, o_LED_G, o_LED_B, o_Cmd_Err, o_Overrun
  );
endinterface

// File: rtl/uart_resp_serializer.sv
// Holds one ASCII response (up to 5 bytes) and feeds it to the UART transmitter
// byte by byte through its DV/Active/Done handshake.
module uart_resp_serializer
  import uart_cmd_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0][7:0] resp,
  input  logic [2:0]      resp_len,
  input  logic            tx_active,
  input  logic            tx_done,
  output logic            tx_dv,
  output logic [7:0]      tx_byte,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [4:0][7:0] buf_q, buf_d;
  logic [2:0]      len_q, len_d;
  logic [2:0]      idx_q, idx_d;
  logic            tx_dv_q, tx_dv_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            last_s;

  assign last_s  = (state_q == TX_WAIT) && tx_done && (idx_q == (len_q - 3'd1));
  // Busy drops in the cycle of the final Done so the parser can resume collecting on the same edge.
  assign busy    = (state_q != COLLECT) && !last_s;
  assign tx_dv   = tx_dv_q;
  assign tx_byte = tx_byte_q;

  // Handshake state register and response buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      buf_q     <= '0;
      len_q     <= 3'd0;
      idx_q     <= 3'd0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // Next-state logic: COLLECT doubles as the idle state of the serializer.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    len_d     = len_q;
    idx_d     = idx_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    case (state_q)
      COLLECT: begin
        if (start) begin
          buf_d   = resp;
          len_d   = resp_len;
          idx_d   = 3'd0;
          state_d = TX_LOAD;
        end else begin
          state_d = COLLECT;
        end
      end
      TX_LOAD: begin
        if (!tx_active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = buf_q[idx_q];
          state_d   = TX_WAIT;
        end else begin
          state_d = TX_LOAD;
        end
      end
      TX_WAIT: begin
        if (last_s) begin
          buf_d   = '0;
          len_d   = 3'd0;
          idx_d   = 3'd0;
          state_d = COLLECT;
        end else if (tx_done) begin
          idx_d   = idx_q + 3'd1;
          state_d = TX_LOAD;
        end else begin
          state_d = TX_WAIT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles ASCII command lines from the UART receiver, drives the RGB LED pins
// and answers each non-empty line with "OK", "ER" or the LED state.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN      = 4,
  parameter int TIMEOUT_CLKS = 25000000
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
  uart_cmd_parser_if.slave bus
);

  localparam int              TW         = $clog2(TIMEOUT_CLKS);
  localparam int              IW         = $clog2(MAX_LEN);
  localparam logic [2:0]      MAX_LEN_W  = 3'(MAX_LEN);
  localparam logic [2:0]      MAX_LEN_P1 = 3'(MAX_LEN + 1);
  localparam logic [TW-1:0]   TMO_LAST   = TW'(TIMEOUT_CLKS - 1);

  state_e                   state_q, state_d;
  logic [MAX_LEN-1:0][7:0]  buf_q, buf_d;
  logic [2:0]               len_q, len_d;
  logic                     too_long_q, too_long_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic [2:0]               led_q, led_d;
  logic                     err_q, err_d;
  logic                     ovr_q, ovr_d;
  logic                     start_s, busy_s, tail1_clr_s, tail2_clr_s, is_term_s;
  logic [4:0][7:0]          resp_s;
  logic [2:0]               resp_len_s;

  assign bus.o_LED_R   = led_q[2];
  assign bus.o_LED_G   = led_q[1];
  assign bus.o_LED_B   = led_q[0];
  assign bus.o_Cmd_Err = err_q;
  assign bus.o_Overrun = ovr_q;
  assign is_term_s     = (bus.i_RX_Byte == ASCII_CR) || (bus.i_RX_Byte == ASCII_LF);

  uart_resp_serializer u_ser (
    .clk       (i_Clock),
    .rst_n     (i_Rst_L),
    .start     (start_s),
    .resp      (resp_s),
    .resp_len  (resp_len_s),
    .tx_active (bus.i_TX_Active),
    .tx_done   (bus.i_TX_Done),
    .tx_dv     (bus.o_TX_DV),
    .tx_byte   (bus.o_TX_Byte),
    .busy      (busy_s)
  );

  // Parser state, line buffer, timeout counter and LED pins.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= COLLECT;
      buf_q      <= '0;
      len_q      <= 3'd0;
      too_long_q <= 1'b0;
      tmo_q      <= '0;
      led_q      <= 3'b111;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      len_q      <= len_d;
      too_long_q <= too_long_d;
      tmo_q      <= tmo_d;
      led_q      <= led_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
    end
  end

  // Unused buffer slots must read back as zero; this guards the decode against stale bytes.
  always_comb begin
    tail1_clr_s = (buf_q[1] == 8'd0);
    tail2_clr_s = 1'b1;
    for (int i = 2; i < MAX_LEN; i++) begin
      if (buf_q[i] != 8'd0) begin
        tail2_clr_s = 1'b0;
      end else begin
        tail2_clr_s = tail2_clr_s;
      end
    end
  end

  // Line collection, timeout, command decode and response construction.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    len_d      = len_q;
    too_long_d = too_long_q;
    tmo_d      = tmo_q;
    led_d      = led_q;
    err_d      = 1'b0;
    ovr_d      = bus.i_RX_DV && (state_q != COLLECT);
    start_s    = 1'b0;
    resp_s     = {8'd0, ASCII_LF, ASCII_CR, ASCII_R, ASCII_E};
    resp_len_s = RESP_LEN_ACK;
    case (state_q)
      COLLECT: begin
        if (bus.i_RX_DV) begin
          tmo_d = '0;
          if (is_term_s) begin
            state_d = (len_q != 3'd0) ? EXEC : COLLECT;
          end else begin
            if (len_q < MAX_LEN_W) begin
              buf_d[len_q[IW-1:0]] = bus.i_RX_Byte;
            end else begin
              too_long_d = 1'b1;
            end
            len_d = (len_q == MAX_LEN_P1) ? len_q : (len_q + 3'd1);
          end
        end else if (len_q != 3'd0) begin
          if (tmo_q == TMO_LAST) begin
            buf_d      = '0;
            len_d      = 3'd0;
            too_long_d = 1'b0;
            tmo_d      = '0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end else begin
          tmo_d = tmo_q;
        end
      end
      EXEC: begin
        start_s    = 1'b1;
        state_d    = TX_LOAD;
        buf_d      = '0;
        len_d      = 3'd0;
        too_long_d = 1'b0;
        tmo_d      = '0;
        if (!too_long_q && (len_q == 3'd2) && tail2_clr_s &&
            ((buf_q[1] == ASCII_0) || (buf_q[1] == ASCII_1)) &&
            ((buf_q[0] == ASCII_R) || (buf_q[0] == ASCII_G) || (buf_q[0] == ASCII_B))) begin
          case (buf_q[0])
            ASCII_R: led_d[2] = (buf_q[1] == ASCII_0);
            ASCII_G: led_d[1] = (buf_q[1] == ASCII_0);
            ASCII_B: led_d[0] = (buf_q[1] == ASCII_0);
            default: led_d    = led_q;
          endcase
          resp_s = {8'd0, ASCII_LF, ASCII_CR, ASCII_K, ASCII_O};
        end else if (!too_long_q && (len_q == 3'd1) && tail1_clr_s && tail2_clr_s &&
                     (buf_q[0] == ASCII_Q)) begin
          resp_s     = {ASCII_LF, ASCII_CR, led_digit(led_q[0]), led_digit(led_q[1]),
                        led_digit(led_q[2])};
          resp_len_s = RESP_LEN_QUERY;
        end else begin
          err_d = 1'b1;
        end
      end
      TX_LOAD: begin
        // The parser parks here while the serializer runs the byte handshake.
        state_d = busy_s ? TX_LOAD : COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver and upstream of the UART transmitter in the pico-ice UART/LED top level.
- Consumes received bytes (data-valid strobe plus byte) and assembles short ASCII command lines.
- Executes each line against the RGB LED state and returns an ASCII response through the transmitter's DV/Active/Done handshake.
- Replaces the ad-hoc "byte == '1'" LED logic with a checked, acknowledged command channel.

Parameters:
- MAX_LEN, 4: maximum command characters (excluding terminator) buffered per line.
- TIMEOUT_CLKS, 25000000: idle clocks after the last received byte before a partial line is discarded (1 s at 25 MHz).

Ports:
- i_Clock  in  1  system clock, the 25 MHz PLL output.
- i_Rst_L  in  1  reset.
- i_RX_DV  in  1  one-cycle strobe: i_RX_Byte is valid.
- i_RX_Byte  in  8  received byte.
- o_TX_DV  out  1  one-cycle strobe: load o_TX_Byte into the transmitter.
- o_TX_Byte  out  8  byte to transmit.
- i_TX_Active  in  1  transmitter busy.
- i_TX_Done  in  1  one-cycle strobe at the end of each transmitted byte.
- o_LED_R / o_LED_G / o_LED_B  out  1 each  LED pin drives, active-low (0 = lit).
- o_Cmd_Err  out  1  one-cycle pulse on each rejected line.
- o_Overrun  out  1  one-cycle pulse on each byte dropped while busy.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All state is cleared asynchronously when i_Rst_L=0.
- Reset values: o_TX_DV=0, o_TX_Byte=0, o_LED_R/G/B=1 (off), o_Cmd_Err=0, o_Overrun=0, state=COLLECT, line buffer empty.
- Terminators are CR (0x0D) and LF (0x0A). An empty line (terminator with 0 buffered characters) is ignored with no response, so CR+LF produces a single response.
- Valid lines, uppercase only:
  - "R0"/"R1", "G0"/"G1", "B0"/"B1": set the LED lit (digit '1') or off (digit '0'). Respond "OK\r\n".
  - "?": respond with three digits, R then G then B, '1' meaning lit, followed by "\r\n". Example: R lit, G off, B lit -> "101\r\n".
  - Anything else, including more than MAX_LEN characters: respond "ER\r\n", pulse o_Cmd_Err, LED state unchanged.
- Overflow: characters beyond MAX_LEN are not stored. A sticky too-long flag forces ER at the terminator.
- States:
  - COLLECT: accept bytes into the buffer. On a non-empty terminator go to EXEC.
  - EXEC: one cycle. Decode, update LEDs, load the response buffer (length 4 or 5). Go to TX_LOAD.
  - TX_LOAD: wait until i_TX_Active=0, then drive o_TX_DV=1 for exactly one cycle with the current byte. Go to TX_WAIT.
  - TX_WAIT: on i_TX_Done, advance the index. After the last byte, clear the buffer and return to COLLECT; otherwise return to TX_LOAD.
- LED timing: an LED output changes on the clock edge that ends EXEC, i.e. 2 cycles after the terminator's i_RX_DV.
- First o_TX_DV occurs no earlier than 2 cycles after the terminator strobe.
- Bytes arriving in EXEC/TX_LOAD/TX_WAIT are dropped, and o_Overrun pulses for each one.
- Timeout:
  - A counter resets on every i_RX_DV while in COLLECT with a non-empty buffer.
  - On reaching TIMEOUT_CLKS-1 with a non-empty buffer, silently clear the buffer and the too-long flag. No response.
  - The counter is frozen while the buffer is empty.
- Same-cycle events: i_RX_DV on the same cycle as the timeout expiry takes priority; the byte is accepted and the counter is restarted.
- i_TX_Done while not in TX_WAIT is ignored.
- Reset mid-response aborts the transmission immediately (o_TX_DV low). The byte already in the transmitter finishes on its own.
- Widths: response index 3 bits, line length counter 3 bits saturating at MAX_LEN+1, timeout counter $clog2(TIMEOUT_CLKS) bits.

Decomposition:
- Package uart_cmd_pkg holds:
  - ASCII constants: CR, LF, 'R', 'G', 'B', '0', '1', '?', 'O', 'K', 'E'.
  - State enum: COLLECT, EXEC, TX_LOAD, TX_WAIT.
  - Response lengths: 4 and 5.
- One sub-module, uart_resp_serializer: holds the 5-byte response buffer and index, and runs the TX_LOAD/TX_WAIT handshake with the transmitter. It exposes start/busy to the parser FSM.

Test Plan:
- Send "R1\r\n" -> o_LED_R goes 1->0 two cycles after the CR strobe; TX bytes 0x4F 0x4B 0x0D 0x0A, exactly one o_TX_DV per i_TX_Done; no response for the LF.
- Send "G1\n", "B1\n", "G0\n", then "?\n" -> LEDs R=1 G=1 B=0 at the pins; final response "001\r\n" (0x30 0x30 0x31 0x0D 0x0A).
- Send "X1\n" and then "R1234\n" -> each returns "ER\r\n" with one o_Cmd_Err pulse; LEDs unchanged.
- Send "R1\n" followed immediately by "G1\n" while the response is still transmitting -> three o_Overrun pulses; o_LED_G stays 1.
- Send "R", wait TIMEOUT_CLKS (bench override 100) cycles, then send "\n" -> no response, o_LED_R stays 1; a following "R1\n" works normally.
- Assert i_Rst_L=0 during the second response byte -> o_TX_DV=0 and LEDs=1 asynchronously; after release, "?\n" returns "000\r\n".
